free_list_ckpt: RTL and testbench

Parametrised physical-register free list for the rename stage. It provides multi-port allocation and release, and adds branch checkpoints: a mispredict restore returns every register allocated after the checkpoint to the pool in one cycle. It sits between rename (alloc, checkpoint take), commit (free) and branch resolution (release, restore).

---
 rtl/core_pkg.sv | 11 +
 rtl/free_list_ckpt_if.sv | 48 ++++
 rtl/prio_pick_n.sv | 26 ++
 rtl/free_list_ckpt.sv | 153 +++++++++++++++
 tb/tb_free_list_ckpt.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared constants and tag types for the rename/free-list slice.
package core_pkg;
  localparam int PREGS      = 48;
  localparam int ARCH_REGS  = 32;
  localparam int CKPT_DEPTH = 4;
  localparam int PTAG_W     = $clog2(PREGS);
  localparam int CKPT_W     = $clog2(CKPT_DEPTH);

  typedef logic [PTAG_W-1:0] ptag_t;
  typedef logic [CKPT_W-1:0] ckpt_id_t;
endpackage

// File: rtl/free_list_ckpt_if.sv
// Rename/commit/branch-unit handshake bundle for free_list_ckpt.
// dbl_free_err is present only when FREE_LIST_DBL_FREE_CHECK_EN is defined.
interface free_list_ckpt_if
  import core_pkg::*;
#(
  parameter int PHYS_REGS   = core_pkg::PREGS,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2,
  parameter int CKPT_DEPTH  = core_pkg::CKPT_DEPTH
);
  localparam int TAG_W = $clog2(PHYS_REGS);
  localparam int ID_W  = $clog2(CKPT_DEPTH);
  localparam int CNT_W = $clog2(PHYS_REGS + 1);

  logic [ALLOC_PORTS-1:0]            alloc_en;
  logic [ALLOC_PORTS-1:0][TAG_W-1:0] alloc_phys;
  logic [ALLOC_PORTS-1:0]            alloc_valid;
  logic [FREE_PORTS-1:0]             free_en;
  logic [FREE_PORTS-1:0][TAG_W-1:0]  free_phys;
  logic [CNT_W-1:0]                  free_count;
  logic                              ckpt_take;
  logic                              ckpt_ready;
  logic [ID_W-1:0]                   ckpt_id;
  logic                              ckpt_release;
  logic                              ckpt_restore;
  logic [ID_W-1:0]                   ckpt_restore_id;
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
  logic                              dbl_free_err;
`endif

  modport master (
    output alloc_en, free_en, free_phys, ckpt_take, ckpt_release,
           ckpt_restore, ckpt_restore_id,
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    input  dbl_free_err,
`endif
    input  alloc_phys, alloc_valid, free_count, ckpt_ready, ckpt_id
  );

  modport slave (
    input  alloc_en, free_en, free_phys, ckpt_take, ckpt_release,
           ckpt_restore, ckpt_restore_id,
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    output dbl_free_err,
`endif
    output alloc_phys, alloc_valid, free_count, ckpt_ready, ckpt_id
  );
endinterface

// File: rtl/prio_pick_n.sv
// Finds the N lowest set bits of a mask; stage n reports the n-th lowest.
module prio_pick_n #(
  parameter int W  = 48,
  parameter int N  = 2,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]         mask,
  output logic [N-1:0][IW-1:0] idx,
  output logic [N-1:0]         valid
);
  logic [W-1:0] rem;

  always_comb begin
    rem   = mask;
    idx   = '0;
    valid = '0;
    for (int n = 0; n < N; n++) begin
      valid[n] = |rem;
      // scanning downward leaves the lowest set bit as the final assignment
      for (int i = W - 1; i >= 0; i--) begin
        if (rem[i]) idx[n] = IW'(i);
      end
      rem = rem & (rem - W'(1));
    end
  end
endmodule

// File: rtl/free_list_ckpt.sv
// Physical-register free list with branch checkpoints for single-cycle mispredict recovery.
// Optional sticky double-free detector enabled by FREE_LIST_DBL_FREE_CHECK_EN.
module free_list_ckpt
  import core_pkg::*;
#(
  parameter int PHYS_REGS   = core_pkg::PREGS,
  parameter int ARCH_REGS   = core_pkg::ARCH_REGS,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2,
  parameter int CKPT_DEPTH  = core_pkg::CKPT_DEPTH
) (
  input logic             clk,
  input logic             reset_n,
  free_list_ckpt_if.slave bus
);
  localparam int TAG_W = $clog2(PHYS_REGS);
  localparam int ID_W  = $clog2(CKPT_DEPTH);
  localparam int CNT_W = $clog2(PHYS_REGS + 1);
  localparam logic [ID_W:0]   CKPT_FULL = (ID_W + 1)'(CKPT_DEPTH);
  localparam logic [ID_W:0]   CNT_ONE   = (ID_W + 1)'(1);
  localparam logic [ID_W-1:0] ID_ONE    = ID_W'(1);

  logic [PHYS_REGS-1:0]                 free_mask_reg, free_mask_next;
  logic [CKPT_DEPTH-1:0][PHYS_REGS-1:0] since_reg, since_next;
  logic [ID_W-1:0]                      head_reg, head_next;
  logic [ID_W-1:0]                      tail_reg, tail_next;
  logic [ID_W:0]                        count_reg, count_next;

  logic [PHYS_REGS-1:0]                 reset_mask;
  logic [PHYS_REGS-1:0]                 alloc_bits, free_bits;
  logic [ALLOC_PORTS-1:0][TAG_W-1:0]    offer_idx;
  logic [ALLOC_PORTS-1:0]               offer_valid;
  logic [CKPT_DEPTH-1:0]                live;
  logic [ID_W-1:0]                      keep_cnt;
  logic [CNT_W-1:0]                     pop_cnt;
  logic                                 take_ok, rel_ok;

  genvar gi;
  generate
    for (gi = 0; gi < PHYS_REGS; gi++) begin : g_rst
      assign reset_mask[gi] = (gi >= ARCH_REGS);
    end
    // a slot is live when its distance from head is below the occupancy
    for (gi = 0; gi < CKPT_DEPTH; gi++) begin : g_live
      logic [ID_W-1:0] offset;
      assign offset   = ID_W'(gi) - head_reg;
      assign live[gi] = ({1'b0, offset} < count_reg);
    end
  endgenerate

  prio_pick_n #(.W(PHYS_REGS), .N(ALLOC_PORTS), .IW(TAG_W)) u_pick (
    .mask  (free_mask_reg),
    .idx   (offer_idx),
    .valid (offer_valid)
  );

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < PHYS_REGS; i++) pop_cnt = pop_cnt + CNT_W'(free_mask_reg[i]);
  end

  assign bus.alloc_phys  = offer_idx;
  assign bus.alloc_valid = offer_valid;
  assign bus.free_count  = pop_cnt;
  assign bus.ckpt_ready  = (count_reg != CKPT_FULL);
  assign bus.ckpt_id     = tail_reg;

  always_comb begin
    alloc_bits = '0;
    for (int a = 0; a < ALLOC_PORTS; a++) begin
      if (bus.alloc_en[a] && offer_valid[a]) alloc_bits[offer_idx[a]] = 1'b1;
    end
    free_bits = '0;
    for (int j = 0; j < FREE_PORTS; j++) begin
      if (bus.free_en[j]) free_bits[bus.free_phys[j]] = 1'b1;
    end
  end

  // slots older than the restore target survive
  assign keep_cnt = bus.ckpt_restore_id - head_reg;
  assign take_ok  = bus.ckpt_take && (count_reg != CKPT_FULL) && !bus.ckpt_restore;

  always_comb begin
    free_mask_next = free_mask_reg | free_bits;
    since_next     = since_reg;
    head_next      = head_reg;
    tail_next      = tail_reg;
    count_next     = count_reg;
    rel_ok         = 1'b0;
    if (bus.ckpt_restore) begin
      free_mask_next = free_mask_next | since_reg[bus.ckpt_restore_id];
      tail_next      = bus.ckpt_restore_id;
      count_next     = {1'b0, keep_cnt};
      rel_ok         = bus.ckpt_release && (keep_cnt != '0);
    end else begin
      free_mask_next = free_mask_next & ~alloc_bits;
      for (int s = 0; s < CKPT_DEPTH; s++) begin
        if (live[s]) since_next[s] = since_next[s] | alloc_bits;
      end
      // the new slot is cleared after the OR so same-cycle allocs stay out of it
      if (take_ok) begin
        since_next[tail_reg] = '0;
        tail_next            = tail_reg + ID_ONE;
        count_next           = count_reg + CNT_ONE;
      end
      rel_ok = bus.ckpt_release && (count_reg != '0);
    end
    if (rel_ok) begin
      head_next  = head_reg + ID_ONE;
      count_next = count_next - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      free_mask_reg <= reset_mask;
      since_reg     <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
    end else begin
      free_mask_reg <= free_mask_next;
      since_reg     <= since_next;
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
    end
  end

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
  logic dbl_hit;
  logic dbl_err_reg;

  always_comb begin
    dbl_hit = 1'b0;
    for (int j = 0; j < FREE_PORTS; j++) begin
      if (bus.free_en[j]) begin
        if (free_mask_reg[bus.free_phys[j]]) dbl_hit = 1'b1;
        for (int k = 0; k < j; k++) begin
          if (bus.free_en[k] && (bus.free_phys[k] == bus.free_phys[j])) dbl_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dbl_err_reg <= 1'b0;
    else          dbl_err_reg <= dbl_err_reg | dbl_hit;
  end

  assign bus.dbl_free_err = dbl_err_reg;
`endif
endmodule

// File: tb/tb_free_list_ckpt.sv
// Randomized scoreboard bench for free_list_ckpt against a queue-based reference model.
module tb_free_list_ckpt;
  import core_pkg::*;

  localparam int NP = PREGS;
  localparam int NA = ARCH_REGS;
  localparam int ND = CKPT_DEPTH;

  typedef struct {
    logic [1:0] valid;
    int         phys0;
    int         phys1;
    int         fcount;
    bit         ready;
    int         id;
    bit         err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  free_list_ckpt_if bus();

  free_list_ckpt dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // reference model: free set, ordered list of open checkpoints, tags allocated since each
  bit m_free[NP];
  int ckq[$];
  bit since[ND][NP];
  int next_id;
  bit m_err;

  function automatic void check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (txn %0d)", nm, act, req, n_txn);
    end
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    int   n = 0;
    e.phys0 = 0;
    e.phys1 = 0;
    for (int t = 0; t < NP; t++) begin
      if (m_free[t]) begin
        if (n == 0) e.phys0 = t;
        else if (n == 1) e.phys1 = t;
        n++;
      end
    end
    e.valid  = {n > 1, n > 0};
    e.fcount = n;
    e.ready  = ckq.size() < ND;
    e.id     = next_id;
    e.err    = m_err;
    return e;
  endfunction

  function automatic void model_reset();
    for (int t = 0; t < NP; t++) m_free[t] = (t >= NA);
    for (int s = 0; s < ND; s++)
      for (int t = 0; t < NP; t++) since[s][t] = 1'b0;
    ckq.delete();
    next_id = 0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_alloc(input int t);
    m_free[t] = 1'b0;
    foreach (ckq[i]) since[ckq[i]][t] = 1'b1;
  endfunction

  task automatic drive_idle();
    bus.alloc_en        = '0;
    bus.free_en         = '0;
    bus.free_phys       = '0;
    bus.ckpt_take       = 1'b0;
    bus.ckpt_release    = 1'b0;
    bus.ckpt_restore    = 1'b0;
    bus.ckpt_restore_id = '0;
  endtask

  task automatic cycle(input bit [1:0] ae, input bit [1:0] fe, input int f0, input int f1,
                       input bit take, input bit rel, input bit rst, input int rid);
    exp_t pre;
    int   pos;
    bus.alloc_en        = ae;
    bus.free_en         = fe;
    bus.free_phys[0]    = PTAG_W'(f0);
    bus.free_phys[1]    = PTAG_W'(f1);
    bus.ckpt_take       = take;
    bus.ckpt_release    = rel;
    bus.ckpt_restore    = rst;
    bus.ckpt_restore_id = CKPT_W'(rid);

    pre = snapshot();
    if (fe[0] && m_free[f0]) m_err = 1'b1;
    if (fe[1] && (m_free[f1] || (fe[0] && f0 == f1))) m_err = 1'b1;

    if (rst) begin
      pos = 0;
      foreach (ckq[i]) if (ckq[i] == rid) pos = i;
      for (int t = 0; t < NP; t++) if (since[rid][t]) m_free[t] = 1'b1;
      while (ckq.size() > pos) void'(ckq.pop_back());
      next_id = rid;
      if (rel && ckq.size() > 0) void'(ckq.pop_front());
    end else begin
      bit take_ok;
      bit rel_ok;
      if (ae[0] && pre.valid[0]) model_alloc(pre.phys0);
      if (ae[1] && pre.valid[1]) model_alloc(pre.phys1);
      take_ok = take && (ckq.size() < ND);
      rel_ok  = rel && (ckq.size() > 0);
      if (rel_ok) void'(ckq.pop_front());
      if (take_ok) begin
        for (int t = 0; t < NP; t++) since[next_id][t] = 1'b0;
        ckq.push_back(next_id);
        next_id = (next_id + 1) % ND;
      end
    end
    if (fe[0]) m_free[f0] = 1'b1;
    if (fe[1]) m_free[f1] = 1'b1;

    @(posedge clk);
    #1;
    exp_q.push_back(snapshot());
  endtask

  task automatic idle();
    cycle(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    drive_idle();
    reset_n = 1'b0;
    model_reset();
    #2;
    check("async_reset_free_count", int'(bus.free_count), NP - NA);
    check("async_reset_ckpt_id", int'(bus.ckpt_id), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.push_back(snapshot());
  endtask

  task automatic random_cycle();
    bit [1:0] ae;
    bit [1:0] fe;
    int       f0, f1, i, j, rid;
    bit       take, rel, rst;
    int       al[$];
    ae = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
    for (int t = 0; t < NP; t++) if (!m_free[t]) al.push_back(t);
    fe = 2'b00;
    f0 = 0;
    f1 = 0;
    if (al.size() > 0 && $urandom_range(0, 2) == 0) begin
      i = $urandom_range(0, al.size() - 1);
      fe[0] = 1'b1;
      f0 = al[i];
      if (al.size() > 1 && $urandom_range(0, 1) == 0) begin
        j = (i + 1 + $urandom_range(0, al.size() - 2)) % al.size();
        fe[1] = 1'b1;
        f1 = al[j];
      end
    end
    take = ($urandom_range(0, 3) == 0);
    rel  = ($urandom_range(0, 5) == 0);
    rst  = (ckq.size() > 0) && ($urandom_range(0, 9) == 0);
    rid  = rst ? ckq[$urandom_range(0, ckq.size() - 1)] : $urandom_range(0, ND - 1);
    cycle(ae, fe, f0, f1, take, rel, rst, rid);
  endtask

  // monitor: compare whatever the DUT presents against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: valid=%b phys={%0d,%0d} free_count=%0d ready=%0b id=%0d",
                 n_txn, bus.alloc_valid, bus.alloc_phys[0], bus.alloc_phys[1],
                 bus.free_count, bus.ckpt_ready, bus.ckpt_id);
        check("alloc_valid", int'(bus.alloc_valid), int'(e.valid));
        if (e.valid[0]) check("alloc_phys0", int'(bus.alloc_phys[0]), e.phys0);
        if (e.valid[1]) check("alloc_phys1", int'(bus.alloc_phys[1]), e.phys1);
        check("free_count", int'(bus.free_count), e.fcount);
        check("ckpt_ready", int'(bus.ckpt_ready), int'(e.ready));
        check("ckpt_id", int'(bus.ckpt_id), e.id);
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
        check("dbl_free_err", int'(bus.dbl_free_err), int'(e.err));
`endif
      end
    end
  end

  initial begin
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.push_back(snapshot());

    // drain the pool, then one free must be offered on port 0 next cycle
    repeat (8) cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    cycle(2'b00, 2'b01, 40, 0, 1'b0, 1'b0, 1'b0, 0);
    idle();

    // checkpoint with same-cycle allocs, later allocs, then restore
    do_reset();
    cycle(2'b11, 2'b00, 0, 0, 1'b1, 1'b0, 1'b0, 0);
    cycle(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    cycle(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1, 0);
    idle();

    // fill checkpoint buffer, overflow take, then release one
    repeat (5) cycle(2'b00, 2'b00, 0, 0, 1'b1, 1'b0, 1'b0, 0);
    cycle(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    idle();

    // restore collides with allocs (dropped) and a free (applied)
    cycle(2'b11, 2'b01, 20, 0, 1'b0, 1'b0, 1'b1, ckq[0]);
    idle();

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    do_reset();
    cycle(2'b00, 2'b01, 32, 0, 1'b0, 1'b0, 1'b0, 0);
    idle();
    idle();
    do_reset();
    cycle(2'b00, 2'b11, 5, 5, 1'b0, 1'b0, 1'b0, 0);
    idle();
`endif

    do_reset();
    repeat (2000) random_cycle();

    // reset while checkpoints are open
    repeat (3) cycle(2'b11, 2'b00, 0, 0, 1'b1, 1'b0, 1'b0, 0);
    do_reset();
    idle();
    idle();

    repeat (4) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
